data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 29 ++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core (master) and the memory responder (slave).
//   Req       : core requests an access; held high until Ready
//   MemWrite  : 1 = store, 0 = load; held stable with Req
//   Addr      : byte address; held stable with Req
//   WriteData : store data; held stable with Req
//   ReadData  : load result, valid with Ready on a load
//   Ready     : one-cycle completion pulse
//   Stall     : core must freeze while high
//   Err       : misaligned or out-of-range access, qualified by Ready
interface data_mem_responder_if;
    logic        Req;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Stall;
    logic        Err;

    modport master (
        output Req, MemWrite, Addr, WriteData,
        input  ReadData, Ready, Stall, Err
    );

    modport slave (
        input  Req, MemWrite, Addr, WriteData,
        output ReadData, Ready, Stall, Err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory interface. Accepts one load/store at a time,
// serves it from a word-addressed RAM after LAT wait states and stalls the core
// until the access completes.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (RAM contents are kept)
//   bus : slave side of data_mem_responder_if
// Parameters: AW = word-address width (2**AW words), LAT = wait states (0 allowed).
module data_mem_responder #(
    parameter int unsigned AW  = 8,
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned Depth = 2 ** AW;
    // $clog2(1) is 0, so LAT = 0 still gets a one-bit counter.
    localparam int unsigned CntW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [CntW-1:0] CntInit = (LAT > 0) ? CntW'(LAT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem [Depth];

    logic [AW-1:0]   req_idx;
    logic            addr_bad;

    assign req_idx  = bus.Addr[AW+1:2];
    assign addr_bad = (bus.Addr[1:0] != 2'b00) || (bus.Addr[31:AW+2] != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Req) begin
                    we_d    = bus.MemWrite;
                    idx_d   = req_idx;
                    wdata_d = bus.WriteData;
                    err_d   = addr_bad;
                    cnt_d   = CntInit;
                    if (addr_bad) begin
                        // Errored loads clear ReadData; errored stores leave it alone.
                        state_d = StResp;
                        if (!bus.MemWrite) rdata_d = '0;
                    end else if (LAT == 0) begin
                        state_d = StResp;
                        if (!bus.MemWrite) rdata_d = mem[req_idx];
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    if (!we_q) rdata_d = mem[idx_q];
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                // Req is ignored here; the next request is taken in IDLE.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Store commits at the end of RESP; a reset in that cycle suppresses it.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == StResp) && we_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.Ready    = (state_q == StResp);
    assign bus.Err      = (state_q == StResp) && err_q;
    assign bus.Stall    = ((state_q == StIdle) && bus.Req) || (state_q == StWait);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with LAT=2 and one with LAT=0.
// Expected responses are queued when a request is driven and checked on Ready
// against a reference memory model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus2();
    data_mem_responder_if bus0();

    data_mem_responder #(.AW(8), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    data_mem_responder #(.AW(8), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          sel0;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem2 [256];
    logic [31:0] mem0 [256];
    logic [31:0] rd2;
    logic [31:0] rd0;
    longint      last_ready_t;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    endfunction

    task automatic drive(input bit sel0, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel0) begin
            bus0.Req = req; bus0.MemWrite = we; bus0.Addr = addr; bus0.WriteData = wdata;
        end else begin
            bus2.Req = req; bus2.MemWrite = we; bus2.Addr = addr; bus2.WriteData = wdata;
        end
    endtask

    task automatic issue(input bit sel0, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        exp_t e;
        e.sel0  = sel0;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.err   = bad_addr(addr);
        e.lat   = e.err ? 1 : ((sel0 ? 0 : 2) + 1);
        sb.push_back(e);
        drive(sel0, 1'b1, we, addr, wdata);
    endtask

    // Waits for Ready, checks latency, Stall/Err shape, Err and ReadData.
    // With corrupt set, the held request fields are changed during cycle 1.
    task automatic await_resp(input string name, input bit corrupt);
        exp_t        e;
        int          cyc;
        bit          got;
        bit          shape_ok;
        logic        rdy, stl, er;
        logic [31:0] rdv, exp_rd;
        logic [7:0]  idx;
        e = sb.pop_front();
        got = 1'b0;
        shape_ok = 1'b1;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            rdy = e.sel0 ? bus0.Ready    : bus2.Ready;
            stl = e.sel0 ? bus0.Stall    : bus2.Stall;
            er  = e.sel0 ? bus0.Err      : bus2.Err;
            rdv = e.sel0 ? bus0.ReadData : bus2.ReadData;
            if (rdy === 1'b1) begin
                got = 1'b1;
                last_ready_t = longint'($time);
                if (stl !== 1'b0) shape_ok = 1'b0;
            end else begin
                if (stl !== 1'b1 || er !== 1'b0) shape_ok = 1'b0;
                if (corrupt && cyc == 1) drive(e.sel0, 1'b1, ~e.we, 32'h24, 32'hFFFF_FFFF);
                cyc++;
            end
        end
        drive(e.sel0, 1'b0, 1'b0, 32'h0, 32'h0);

        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s timeout: Ready seen=0 required=1", name);
            return;
        end
        tests++;
        if (cyc !== e.lat) begin
            fails++;
            $display("FAIL %s latency: got cycle %0d required %0d", name, cyc, e.lat);
        end
        tests++;
        if (shape_ok !== 1'b1) begin
            fails++;
            $display("FAIL %s stall/err shape: got bad required clean", name);
        end
        tests++;
        if (er !== e.err) begin
            fails++;
            $display("FAIL %s err: got %0b required %0b", name, er, e.err);
        end

        idx = e.addr[9:2];
        exp_rd = e.sel0 ? rd0 : rd2;
        if (!e.we) begin
            exp_rd = e.err ? 32'h0 : (e.sel0 ? mem0[idx] : mem2[idx]);
            if (e.sel0) rd0 = exp_rd; else rd2 = exp_rd;
        end else if (!e.err) begin
            if (e.sel0) mem0[idx] = e.wdata; else mem2[idx] = e.wdata;
        end
        tests++;
        if (rdv !== exp_rd) begin
            fails++;
            $display("FAIL %s readdata: got %08h required %08h", name, rdv, exp_rd);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus2.ReadData, bus2.Ready, bus2.Stall, bus2.Err} !== 35'd0) begin
            fails++;
            $display("FAIL reset_lat2: got rd=%08h rdy=%0b stall=%0b err=%0b required all 0",
                     bus2.ReadData, bus2.Ready, bus2.Stall, bus2.Err);
        end
        tests++;
        if ({bus0.ReadData, bus0.Ready, bus0.Stall, bus0.Err} !== 35'd0) begin
            fails++;
            $display("FAIL reset_lat0: got rd=%08h rdy=%0b stall=%0b err=%0b required all 0",
                     bus0.ReadData, bus0.Ready, bus0.Stall, bus0.Err);
        end
        rd2 = 32'h0;
        rd0 = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_load_basic();
        issue(1'b0, 1'b0, 32'h10, 32'h0);
        await_resp("load_0x10", 1'b0);
    endtask

    task automatic test_store_top();
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 32'h3FC, 32'hDEAD_BEEF);
        await_resp("store_top", 1'b0);
        issue(1'b0, 1'b0, 32'h3FC, 32'h0);
        await_resp("load_top", 1'b0);
    endtask

    task automatic test_errors();
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 32'h6, 32'h0);
        await_resp("load_misaligned", 1'b0);
        issue(1'b0, 1'b1, 32'h400, 32'h1111_1111);
        await_resp("store_out_of_range", 1'b0);
        issue(1'b0, 1'b0, 32'h3FC, 32'h0);
        await_resp("load_top_unchanged", 1'b0);
    endtask

    task automatic test_latched_fields();
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 32'h20, 32'h1234_5678);
        await_resp("store_latched", 1'b1);
        issue(1'b0, 1'b0, 32'h20, 32'h0);
        await_resp("load_0x20", 1'b0);
        issue(1'b0, 1'b0, 32'h24, 32'h0);
        await_resp("load_0x24", 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        bit ready_seen;
        ready_seen = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5);
        repeat (3) begin
            @(negedge clk);
            if (bus2.Ready === 1'b1) ready_seen = 1'b1;
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        if (bus2.Ready === 1'b1) ready_seen = 1'b1;
        tests++;
        if ({bus2.ReadData, bus2.Ready, bus2.Stall, bus2.Err} !== 35'd0) begin
            fails++;
            $display("FAIL reset_mid_wait outputs: got rd=%08h rdy=%0b stall=%0b err=%0b required 0",
                     bus2.ReadData, bus2.Ready, bus2.Stall, bus2.Err);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        if (bus2.Ready === 1'b1) ready_seen = 1'b1;
        tests++;
        if (ready_seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_wait ready: got pulse=1 required 0");
        end
        rd2 = 32'h0;
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 32'h40, 32'h0);
        await_resp("load_after_abort", 1'b0);
    endtask

    task automatic test_back_to_back();
        longint t1;
        @(posedge clk); #1;
        issue(1'b1, 1'b1, 32'h8, 32'h55AA_55AA);
        await_resp("lat0_store", 1'b0);
        issue(1'b1, 1'b0, 32'h8, 32'h0);
        await_resp("lat0_load_a", 1'b0);
        t1 = last_ready_t;
        issue(1'b1, 1'b0, 32'hC, 32'h0);
        await_resp("lat0_load_b", 1'b0);
        tests++;
        if (last_ready_t - t1 !== 64'd20) begin
            fails++;
            $display("FAIL lat0_back_to_back spacing: got %0d required 20", last_ready_t - t1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem2[i] = 32'h0;
            mem0[i] = 32'h0;
        end
        rd2 = 32'h0;
        rd0 = 32'h0;
        last_ready_t = 0;
        test_reset();
        test_load_basic();
        test_store_top();
        test_errors();
        test_latched_fields();
        test_reset_mid_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
